// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader, the writer side of the instruction/data memory.
// Accepts a framed byte stream (SYNC, N hi, N lo, 4*N data bytes, optional checksum),
// assembles big-endian 32-bit words, writes them from BASE_ADDR upward and raises
// core_run after a good frame.
// Optional feature macro: PROG_LOADER_CSUM_EN (trailing XOR checksum byte).
module prog_loader #(
    parameter int         ADDR_W    = 10,
    parameter int         BASE_ADDR = 0,
    parameter int         MAX_WORDS = 1024,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       words_written,
    output logic              core_run,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        FLUSH,
        DONE,
        ERR
    } state_t;

    localparam logic [16:0]       MAX_N = 17'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t      state;
    logic [15:0] len;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;   // low three bytes of the word being assembled
`ifdef PROG_LOADER_CSUM_EN
    logic [7:0]  acc;
`endif

    logic        xfer;
    logic [15:0] len_next;
    logic [31:0] word_next;
    logic        last_word;

    // Handshake and next-value helpers shared by several states.
    always_comb begin
        xfer      = in_valid & in_ready;
        len_next  = {len[15:8], in_data};
        word_next = {asm_word, in_data};
        last_word = (words_written + 16'd1) == len;
    end

    // Frame parser FSM with all outputs registered.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state         <= IDLE;
            // NOTE: in_ready resets low and only rises one cycle later from IDLE,
            // so no byte can be taken in the cycle right after reset.
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= BASE;
            mem_wdata     <= 32'd0;
            words_written <= 16'd0;
            core_run      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            len           <= 16'd0;
            byte_cnt      <= 2'd0;
            asm_word      <= 24'd0;
`ifdef PROG_LOADER_CSUM_EN
            acc           <= 8'd0;
`endif
        end else begin
            // NOTE: strobes default low every cycle; branches below raise them for one cycle.
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (xfer && in_data == SYNC_BYTE) begin
                        state <= LEN_HI;
                    end
                end

                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        state     <= LEN_LO;
                    end
                end

                LEN_LO: begin
                    if (xfer) begin
                        len <= len_next;
                        if ({1'b0, len_next} > MAX_N) begin
                            state    <= ERR;
                            err      <= 1'b1;
                            in_ready <= 1'b0;
                        end else begin
                            words_written <= 16'd0;
                            byte_cnt      <= 2'd0;
`ifdef PROG_LOADER_CSUM_EN
                            acc           <= 8'd0;
`endif
                            if (len_next == 16'd0) begin
`ifdef PROG_LOADER_CSUM_EN
                                state    <= CSUM;
`else
                                state    <= DONE;
                                done     <= 1'b1;
                                core_run <= 1'b1;
                                in_ready <= 1'b0;
`endif
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        asm_word <= word_next[23:0];
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef PROG_LOADER_CSUM_EN
                        acc      <= acc ^ in_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            mem_we        <= 1'b1;
                            mem_wdata     <= word_next;
                            mem_addr      <= BASE + words_written[ADDR_W-1:0];
                            words_written <= words_written + 16'd1;
                            if (last_word) begin
`ifdef PROG_LOADER_CSUM_EN
                                state    <= CSUM;
`else
                                // Hold off done until the final write strobe has gone out.
                                state    <= FLUSH;
                                in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end

`ifdef PROG_LOADER_CSUM_EN
                CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == acc) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            core_run <= 1'b1;
                        end else begin
                            state <= ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif

                FLUSH: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    core_run <= 1'b1;
                end

                DONE: begin
                    in_ready <= 1'b0;
                end

                ERR: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: frames are driven at full rate, writes and
// pulses are logged by a negedge monitor, and results are compared to hand-computed values.
module tb_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst  = 1'b1;
    logic [7:0]  in_data  = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] words_written;
    logic        core_run;
    logic        done;
    logic        err;

    prog_loader dut (
        .clk1          (clk1),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .words_written (words_written),
        .core_run      (core_run),
        .done          (done),
        .err           (err)
    );

    always #5 clk1 = ~clk1;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int xfer_cyc;
    int data_end_cyc;
    int done_cnt;
    int err_cnt;
    int done_cyc;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];

    always @(posedge clk1) cyc <= cyc + 1;

    // Monitor: log every write and count the done/err pulses, sampled mid-cycle.
    always @(negedge clk1) begin
        if (mem_we) begin
            wa.push_back(32'(mem_addr));
            wd.push_back(mem_wdata);
            wc.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        done_cyc = -1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk1);
        clear_mon();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_mem_we"}, 32'(mem_we), 0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_words"}, 32'(words_written), 0);
        check({tag, "_core_run"}, 32'(core_run), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // Present one byte and return at the negedge after it has been accepted.
    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && k < 50) begin
            @(negedge clk1);
            k++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 1);
        @(negedge clk1);
        xfer_cyc = cyc;
        in_valid = 1'b0;
    endtask

    // Full frame; bad_csum flips the checksum when the checksum byte is present.
    task automatic send_frame(input logic [31:0] w[$], input logic bad_csum);
        logic [7:0]  cs = 8'd0;
        logic [15:0] n  = 16'(w.size());
        logic [31:0] x;
        send_byte(8'hA5);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        foreach (w[i]) begin
            x = w[i];
            for (int j = 3; j >= 0; j--) begin
                send_byte(x[8*j +: 8]);
                cs = cs ^ x[8*j +: 8];
            end
        end
        data_end_cyc = xfer_cyc;
`ifdef PROG_LOADER_CSUM_EN
        send_byte(cs ^ {7'd0, bad_csum});
`else
        if (bad_csum) cs = ~cs;  // no checksum byte in this build
`endif
    endtask

    // Frame A: two words; checks writes, timing and success outputs.
    task automatic run_frame_a(input string tag);
        logic [31:0] fa[$] = '{32'h0000002A, 32'h12345678};
        send_frame(fa, 1'b0);
        repeat (4) @(negedge clk1);
        check({tag, "_nwrites"}, 32'(wa.size()), 2);
        check({tag, "_addr0"}, wa[0], 0);
        check({tag, "_data0"}, wd[0], 32'h0000002A);
        check({tag, "_addr1"}, wa[1], 1);
        check({tag, "_data1"}, wd[1], 32'h12345678);
        check({tag, "_we_spacing"}, 32'(wc[1] - wc[0]), 4);
        check({tag, "_we_latency"}, 32'(wc[1] - data_end_cyc), 0);
        check({tag, "_done_after_we"}, 32'(done_cyc - wc[1]), 1);
        check({tag, "_words"}, 32'(words_written), 2);
        check({tag, "_done_cnt"}, 32'(done_cnt), 1);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
        check({tag, "_core_run"}, 32'(core_run), 1);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
    endtask

    initial begin
        logic [31:0] big[$];
        logic [31:0] fb[$] = '{32'hA5000001, 32'h000000A5};
        logic [31:0] empty[$];
        int nbad_big;

        // Reset state and the one-cycle ready holdoff after reset.
        do_reset();
        check_reset_vals("reset");
        @(negedge clk1);
        check("ready_after_reset", 32'(in_ready), 1);

        // Basic frame.
        run_frame_a("frame_a");

        // Leading junk bytes are discarded in IDLE.
        do_reset();
        @(negedge clk1);
        send_byte(8'h00);
        send_byte(8'hFF);
        check("junk_no_write", 32'(wa.size()), 0);
        run_frame_a("junk_then_a");

        // Length above MAX_WORDS: error after the third byte, then recovery.
        do_reset();
        @(negedge clk1);
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        check("len_err_pulse_now", 32'(err), 1);
        repeat (2) @(negedge clk1);
        check("len_err_cnt", 32'(err_cnt), 1);
        check("len_err_no_write", 32'(wa.size()), 0);
        check("len_err_core_run", 32'(core_run), 0);
        check("len_err_ready_back", 32'(in_ready), 1);
        clear_mon();
        run_frame_a("after_len_err");

`ifdef PROG_LOADER_CSUM_EN
        // Bad checksum: writes stay, error pulse, then a good frame succeeds.
        do_reset();
        @(negedge clk1);
        fb = '{32'h0000002A, 32'h12345678};
        send_frame(fb, 1'b1);
        repeat (3) @(negedge clk1);
        check("csum_bad_nwrites", 32'(wa.size()), 2);
        check("csum_bad_err_cnt", 32'(err_cnt), 1);
        check("csum_bad_done_cnt", 32'(done_cnt), 0);
        check("csum_bad_core_run", 32'(core_run), 0);
        check("csum_bad_ready", 32'(in_ready), 1);
        clear_mon();
        run_frame_a("after_csum_err");
        fb = '{32'hA5000001, 32'h000000A5};
`endif

        // N == 0: no writes, success.
        do_reset();
        @(negedge clk1);
        send_frame(empty, 1'b0);
        repeat (3) @(negedge clk1);
        check("n0_nwrites", 32'(wa.size()), 0);
        check("n0_done_cnt", 32'(done_cnt), 1);
        check("n0_core_run", 32'(core_run), 1);
        check("n0_in_ready", 32'(in_ready), 0);

        // Reset one cycle after the second data byte of a word.
        do_reset();
        @(negedge clk1);
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b1;
        @(negedge clk1);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        repeat (3) @(negedge clk1);
        check("mid_rst_no_write", 32'(wa.size()), 0);

        // Reset sampled with the fourth byte: no write strobe at all.
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        in_data  = 8'h44;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk1);
        in_valid = 1'b0;
        check("rst_4th_we", 32'(mem_we), 0);
        check("rst_4th_words", 32'(words_written), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk1);
        check("rst_4th_no_write", 32'(wa.size()), 0);

        // Following frame lands at BASE_ADDR; SYNC values inside data are plain data.
        send_frame(fb, 1'b0);
        repeat (4) @(negedge clk1);
        check("post_rst_nwrites", 32'(wa.size()), 2);
        check("post_rst_addr0", wa[0], 0);
        check("post_rst_data0", wd[0], 32'hA5000001);
        check("post_rst_data1", wd[1], 32'h000000A5);
        check("post_rst_core_run", 32'(core_run), 1);

        // Largest accepted frame, N == MAX_WORDS.
        do_reset();
        @(negedge clk1);
        for (int i = 0; i < 1024; i++) big.push_back(32'(i) ^ 32'hC0DE0000);
        send_frame(big, 1'b0);
        repeat (4) @(negedge clk1);
        check("max_nwrites", 32'(wa.size()), 1024);
        nbad_big = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] !== 32'(i) || wd[i] !== (32'(i) ^ 32'hC0DE0000)) nbad_big++;
        end
        check("max_contents", 32'(nbad_big), 0);
        check("max_words", 32'(words_written), 1024);
        check("max_done_cnt", 32'(done_cnt), 1);
        check("max_core_run", 32'(core_run), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
